// File: rtl/spb_pkg.sv
// Shared types and constants for the SP256K-based pixel buffer.
package spb_pkg;

    // Bank power/access state. Only ST_RUN is reachable when SPB_SLEEP_EN is undefined.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SLEEP = 2'd2,
        ST_WAKE  = 2'd3
    } spb_state_e;

    localparam int unsigned SPRAM_AW = 14;
    localparam int unsigned SPRAM_DW = 16;

    // Bank number encoded above the 14-bit per-bank address.
    function automatic int unsigned bank_index(input logic [15:0] addr);
        return 32'(addr >> SPRAM_AW);
    endfunction

endpackage

// File: rtl/SP256K.sv
// Behavioural stand-in for the SP256K 16K x 16 single-port SRAM primitive.
// MASKWE[n]=1 enables the write of nibble n. Contents are not reset.
module SP256K (
    input  logic [13:0] AD,
    input  logic [15:0] DI,
    input  logic [3:0]  MASKWE,
    input  logic        WE,
    input  logic        CS,
    input  logic        CK,
    input  logic        STDBY,
    input  logic        SLEEP,
    input  logic        PWROFF_N,
    output logic [15:0] DO
);

    logic [15:0] mem_q [16384];
    logic        active;

    assign active = CS & ~SLEEP & ~STDBY & PWROFF_N;

    // Single port: either a masked write or a registered read per cycle.
    always_ff @(posedge CK) begin
        if (active) begin
            if (WE) begin
                for (int unsigned n = 0; n < 4; n++) begin
                    if (MASKWE[n]) begin
                        mem_q[AD][n*4 +: 4] <= DI[n*4 +: 4];
                    end
                end
            end else begin
                DO <= mem_q[AD];
            end
        end
    end

endmodule

// File: rtl/spb_wr_fifo.sv
// Write-side FIFO holding {addr, data} entries waiting for a free bank cycle.
// Push when full and pop when empty are ignored.
module spb_wr_fifo #(
    parameter  int unsigned DW    = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned LW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    assign full      = (level_q == LW'(DEPTH));
    assign empty     = (level_q == '0);
    assign level     = level_q;
    assign head_data = mem_q[rd_ptr_q];
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;

    // Next-state for storage, pointers (wrap at power-of-two depth) and level.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/spram_pixel_buffer.sv
// Pixel frame store over NUM_BANKS SP256K banks. Reads always win a bank;
// writes queue in spb_wr_fifo and drain into free banks one per cycle.
// Optional sleep handshake (SLEEP_REQ/SLEEP_ACK) enabled by `define SPB_SLEEP_EN.
module spram_pixel_buffer
    import spb_pkg::*;
#(
    parameter  int unsigned NUM_BANKS   = 2,
    parameter  int unsigned PIXEL_W     = 12,
    parameter  int unsigned WFIFO_DEPTH = 4,
    parameter  int unsigned WAKE_CYCLES = 8,
    localparam int unsigned AW          = SPRAM_AW + $clog2(NUM_BANKS),
    localparam int unsigned LW          = $clog2(WFIFO_DEPTH) + 1
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               WR_VALID,
    output logic               WR_READY,
    input  logic [AW-1:0]      WR_ADDR,
    input  logic [PIXEL_W-1:0] WR_DATA,
    input  logic               RD_REQ,
    input  logic [AW-1:0]      RD_ADDR,
    output logic               RD_VALID,
    output logic [PIXEL_W-1:0] RD_DATA,
`ifdef SPB_SLEEP_EN
    input  logic               SLEEP_REQ,
    output logic               SLEEP_ACK,
`endif
    output logic [LW-1:0]      FIFO_LEVEL
);

    localparam int unsigned BSW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int unsigned EW  = AW + PIXEL_W;

    spb_state_e          state;
    logic                bank_sleep;
    logic                alive_q, alive_d;
    logic                rd_valid_q, rd_valid_d;
    logic [BSW-1:0]      rd_bank_q, rd_bank_d;
    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [EW-1:0]       fifo_head;
    logic [AW-1:0]       head_addr;
    logic [PIXEL_W-1:0]  head_data;
    logic                access_ok, rd_fire;
    logic [BSW-1:0]      rd_bank, wr_bank;
    logic [SPRAM_DW-1:0] bank_do [NUM_BANKS];
    logic [SPRAM_DW-1:0] rd_word;

    assign head_addr = fifo_head[EW-1:PIXEL_W];
    assign head_data = fifo_head[PIXEL_W-1:0];
    assign rd_bank   = BSW'(bank_index(16'(RD_ADDR)));
    assign wr_bank   = BSW'(bank_index(16'(head_addr)));

    // Arbitration: a read owns its bank; the FIFO head drains only into another bank.
    always_comb begin
        access_ok = (state == ST_RUN) || (state == ST_DRAIN);
        rd_fire   = RD_REQ & access_ok;
        fifo_pop  = ~fifo_empty & access_ok & ~(rd_fire && (rd_bank == wr_bank));
        WR_READY  = alive_q & ~fifo_full & (state == ST_RUN);
        fifo_push = WR_VALID & WR_READY;
    end

    spb_wr_fifo #(
        .DW    (EW),
        .DEPTH (WFIFO_DEPTH)
    ) u_wr_fifo (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .push      (fifo_push),
        .push_data ({WR_ADDR, WR_DATA}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (FIFO_LEVEL)
    );

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic rd_hit, wr_hit;
        assign rd_hit = rd_fire && (rd_bank == BSW'(b));
        assign wr_hit = fifo_pop && (wr_bank == BSW'(b));

        SP256K u_spram (
            .AD       (rd_hit ? RD_ADDR[SPRAM_AW-1:0] : head_addr[SPRAM_AW-1:0]),
            .DI       (SPRAM_DW'(head_data)),
            .MASKWE   (4'b1111),
            .WE       (wr_hit),
            .CS       (rd_hit | wr_hit),
            .CK       (CLK),
            .STDBY    (1'b0),
            .SLEEP    (bank_sleep),
            .PWROFF_N (1'b1),
            .DO       (bank_do[b])
        );
    end

    // Read pipeline: remember which bank answers next cycle.
    always_comb begin
        alive_d    = 1'b1;
        rd_valid_d = rd_fire;
        rd_bank_d  = rd_fire ? rd_bank : rd_bank_q;
    end

    // Read pipeline and post-reset ready registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            alive_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_bank_q  <= '0;
        end else begin
            alive_q    <= alive_d;
            rd_valid_q <= rd_valid_d;
            rd_bank_q  <= rd_bank_d;
        end
    end

    assign rd_word  = bank_do[rd_bank_q];
    assign RD_VALID = rd_valid_q;
    assign RD_DATA  = rd_valid_q ? rd_word[PIXEL_W-1:0] : '0;

    if (PIXEL_W < SPRAM_DW) begin : g_pad
        logic unused_rd_bits;
        assign unused_rd_bits = ^rd_word[SPRAM_DW-1:PIXEL_W];
    end

`ifdef SPB_SLEEP_EN
    localparam int unsigned WCW = $clog2(WAKE_CYCLES + 1);

    spb_state_e     state_q;
    logic           sleep_ack_q;
    logic           bank_sleep_q;
    logic [WCW-1:0] wake_cnt_q;

    // Power FSM: drain queued writes, sleep the banks, then hold WAKE_CYCLES before RUN.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_RUN;
            sleep_ack_q  <= 1'b0;
            bank_sleep_q <= 1'b0;
            wake_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (SLEEP_REQ) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!SLEEP_REQ) begin
                        state_q <= ST_RUN;
                    end else if (fifo_empty) begin
                        state_q      <= ST_SLEEP;
                        sleep_ack_q  <= 1'b1;
                        bank_sleep_q <= 1'b1;
                    end
                end
                ST_SLEEP: begin
                    if (!SLEEP_REQ) begin
                        state_q      <= ST_WAKE;
                        sleep_ack_q  <= 1'b0;
                        bank_sleep_q <= 1'b0;
                        wake_cnt_q   <= WCW'(WAKE_CYCLES);
                    end
                end
                ST_WAKE: begin
                    if (wake_cnt_q <= WCW'(1)) begin
                        state_q <= ST_RUN;
                    end else begin
                        wake_cnt_q <= wake_cnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign state      = state_q;
    assign bank_sleep = bank_sleep_q;
    assign SLEEP_ACK  = sleep_ack_q;
`else
    logic [31:0] unused_wake_cycles;
    assign unused_wake_cycles = WAKE_CYCLES;
    assign state      = ST_RUN;
    assign bank_sleep = 1'b0;
`endif

endmodule

// File: tb/tb_spram_pixel_buffer.sv
// Directed self-checking bench for spram_pixel_buffer (NUM_BANKS=2, PIXEL_W=12,
// WFIFO_DEPTH=4, WAKE_CYCLES=8). Sleep scenarios need SPB_SLEEP_EN.
module tb_spram_pixel_buffer;

    localparam int unsigned WAKE = 8;

    logic        CLK;
    logic        RESET_N;
    logic        WR_VALID;
    logic        WR_READY;
    logic [14:0] WR_ADDR;
    logic [11:0] WR_DATA;
    logic        RD_REQ;
    logic [14:0] RD_ADDR;
    logic        RD_VALID;
    logic [11:0] RD_DATA;
    logic [2:0]  FIFO_LEVEL;
`ifdef SPB_SLEEP_EN
    logic        SLEEP_REQ;
    logic        SLEEP_ACK;
`endif

    int total = 0;
    int bad   = 0;

    spram_pixel_buffer #(
        .NUM_BANKS   (2),
        .PIXEL_W     (12),
        .WFIFO_DEPTH (4),
        .WAKE_CYCLES (WAKE)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .WR_VALID   (WR_VALID),
        .WR_READY   (WR_READY),
        .WR_ADDR    (WR_ADDR),
        .WR_DATA    (WR_DATA),
        .RD_REQ     (RD_REQ),
        .RD_ADDR    (RD_ADDR),
        .RD_VALID   (RD_VALID),
        .RD_DATA    (RD_DATA),
`ifdef SPB_SLEEP_EN
        .SLEEP_REQ  (SLEEP_REQ),
        .SLEEP_ACK  (SLEEP_ACK),
`endif
        .FIFO_LEVEL (FIFO_LEVEL)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic push_pixel(input logic [14:0] a, input logic [11:0] d);
        int n = 0;
        WR_VALID = 1'b1; WR_ADDR = a; WR_DATA = d;
        while (!WR_READY && n < 50) begin @(negedge CLK); n++; end
        if (!WR_READY) begin
            total++; bad++;
            $display("FAIL push_timeout got=ready0 exp=ready1 addr=%0h", a);
        end
        @(negedge CLK);
        WR_VALID = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (FIFO_LEVEL != 0 && n < 60) begin @(negedge CLK); n++; end
        total++;
        if (FIFO_LEVEL !== 3'd0) begin bad++; $display("FAIL drain_timeout got=%0d exp=0", FIFO_LEVEL); end
    endtask

    task automatic do_read(input logic [14:0] a, output logic v, output logic [11:0] d);
        RD_ADDR = a; RD_REQ = 1'b1;
        @(negedge CLK);
        RD_REQ = 1'b0;
        v = RD_VALID; d = RD_DATA;
    endtask

    task automatic test_reset();
        @(negedge CLK); @(negedge CLK);
        total++; if (WR_READY !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", WR_READY); end
        total++; if (RD_VALID !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", RD_VALID); end
        total++; if (RD_DATA !== 12'h000) begin bad++; $display("FAIL rst_data got=%h exp=000", RD_DATA); end
        total++; if (FIFO_LEVEL !== 3'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", FIFO_LEVEL); end
`ifdef SPB_SLEEP_EN
        total++; if (SLEEP_ACK !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b exp=0", SLEEP_ACK); end
`endif
        RESET_N = 1'b1;
        @(negedge CLK);
        total++; if (WR_READY !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b exp=1", WR_READY); end
    endtask

    task automatic test_basic();
        logic v; logic [11:0] d;
        push_pixel(15'h0010, 12'h0AB);
        push_pixel(15'h4010, 12'hFFF);
        wait_empty();
        do_read(15'h0010, v, d);
        total++; if (v !== 1'b1) begin bad++; $display("FAIL basic_v0 got=%b exp=1", v); end
        total++; if (d !== 12'h0AB) begin bad++; $display("FAIL basic_d0 got=%h exp=0ab", d); end
        do_read(15'h4010, v, d);
        total++; if (v !== 1'b1) begin bad++; $display("FAIL basic_v1 got=%b exp=1", v); end
        total++; if (d !== 12'hFFF) begin bad++; $display("FAIL basic_d1 got=%h exp=fff", d); end
        @(negedge CLK);
        total++; if (RD_VALID !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b exp=0", RD_VALID); end
    endtask

    task automatic test_stall();
        int wi = 0;
        logic acc;
        logic v; logic [11:0] d;
        for (int c = 0; c < 14; c++) begin
            if (c == 6) begin
                total++; if (FIFO_LEVEL !== 3'd4) begin bad++; $display("FAIL stall_level got=%0d exp=4", FIFO_LEVEL); end
                total++; if (WR_READY !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b exp=0", WR_READY); end
                total++; if (wi != 4) begin bad++; $display("FAIL stall_accepted got=%0d exp=4", wi); end
            end
            if (c == 10) begin
                total++; if (FIFO_LEVEL !== 3'd4) begin bad++; $display("FAIL stall_held got=%0d exp=4", FIFO_LEVEL); end
            end
            RD_REQ   = (c < 10);
            RD_ADDR  = 15'(c);
            WR_VALID = (wi < 6);
            WR_ADDR  = 15'(15'h0200 + wi);
            WR_DATA  = 12'(12'h3C0 + wi * 17);
            acc      = WR_VALID && WR_READY;
            @(negedge CLK);
            if (acc) wi++;
        end
        WR_VALID = 1'b0; RD_REQ = 1'b0;
        total++; if (wi != 6) begin bad++; $display("FAIL stall_total got=%0d exp=6", wi); end
        wait_empty();
        for (int i = 0; i < 6; i++) begin
            do_read(15'(15'h0200 + i), v, d);
            total++;
            if (v !== 1'b1 || d !== 12'(12'h3C0 + i * 17)) begin
                bad++; $display("FAIL stall_readback%0d got=%b/%h exp=1/%h", i, v, d, 12'(12'h3C0 + i * 17));
            end
        end
    endtask

    task automatic test_no_stall();
        int wi = 0;
        int maxl = 0;
        logic acc;
        logic v; logic [11:0] d;
        for (int c = 0; c < 8; c++) begin
            RD_REQ   = 1'b1;
            RD_ADDR  = 15'(15'h0010 + c);
            WR_VALID = (wi < 5);
            WR_ADDR  = 15'(15'h4200 + wi);
            WR_DATA  = 12'(12'hA00 + wi);
            acc      = WR_VALID && WR_READY;
            @(negedge CLK);
            if (acc) wi++;
            if (int'(FIFO_LEVEL) > maxl) maxl = int'(FIFO_LEVEL);
        end
        RD_REQ = 1'b0; WR_VALID = 1'b0;
        total++; if (maxl > 1) begin bad++; $display("FAIL nostall_maxlevel got=%0d exp<=1", maxl); end
        total++; if (wi != 5) begin bad++; $display("FAIL nostall_accepted got=%0d exp=5", wi); end
        wait_empty();
        do_read(15'h4200, v, d);
        total++; if (d !== 12'hA00) begin bad++; $display("FAIL nostall_rb0 got=%h exp=a00", d); end
        do_read(15'h4204, v, d);
        total++; if (d !== 12'hA04) begin bad++; $display("FAIL nostall_rb4 got=%h exp=a04", d); end
    endtask

    task automatic test_no_forward();
        logic v; logic [11:0] d;
        push_pixel(15'h0050, 12'h0AA);
        wait_empty();
        WR_VALID = 1'b1; WR_ADDR = 15'h0050; WR_DATA = 12'h123;
        total++; if (WR_READY !== 1'b1) begin bad++; $display("FAIL nofwd_ready got=%b exp=1", WR_READY); end
        @(negedge CLK);
        WR_VALID = 1'b0;
        RD_REQ = 1'b1; RD_ADDR = 15'h0050;
        @(negedge CLK);
        RD_REQ = 1'b0;
        total++; if (RD_VALID !== 1'b1) begin bad++; $display("FAIL nofwd_valid got=%b exp=1", RD_VALID); end
        total++; if (RD_DATA !== 12'h0AA) begin bad++; $display("FAIL nofwd_old got=%h exp=0aa", RD_DATA); end
        total++; if (FIFO_LEVEL !== 3'd1) begin bad++; $display("FAIL nofwd_level got=%0d exp=1", FIFO_LEVEL); end
        wait_empty();
        do_read(15'h0050, v, d);
        total++; if (d !== 12'h123) begin bad++; $display("FAIL nofwd_new got=%h exp=123", d); end
    endtask

`ifdef SPB_SLEEP_EN
    task automatic test_sleep();
        int n;
        logic got;
        logic [11:0] d;
        for (int c = 0; c < 3; c++) begin
            RD_REQ = 1'b1; RD_ADDR = 15'h4000;
            WR_VALID = 1'b1; WR_ADDR = 15'(15'h4100 + c); WR_DATA = 12'(12'hB10 + c);
            @(negedge CLK);
        end
        WR_VALID = 1'b0; RD_REQ = 1'b0;
        total++; if (FIFO_LEVEL !== 3'd3) begin bad++; $display("FAIL sleep_queued got=%0d exp=3", FIFO_LEVEL); end
        SLEEP_REQ = 1'b1;
        @(negedge CLK);
        total++; if (WR_READY !== 1'b0) begin bad++; $display("FAIL drain_ready got=%b exp=0", WR_READY); end
        n = 0;
        while (!SLEEP_ACK && n < 20) begin @(negedge CLK); n++; end
        total++; if (SLEEP_ACK !== 1'b1) begin bad++; $display("FAIL sleep_ack got=%b exp=1", SLEEP_ACK); end
        total++; if (FIFO_LEVEL !== 3'd0) begin bad++; $display("FAIL sleep_level got=%0d exp=0", FIFO_LEVEL); end
        RD_REQ = 1'b1; RD_ADDR = 15'h4100;
        @(negedge CLK);
        RD_REQ = 1'b0;
        total++; if (RD_VALID !== 1'b0) begin bad++; $display("FAIL asleep_read got=%b exp=0", RD_VALID); end
        SLEEP_REQ = 1'b0; RD_REQ = 1'b1; RD_ADDR = 15'h4101;
        n = 0; got = 1'b0; d = '0;
        while (!got && n < 40) begin
            @(negedge CLK);
            n++;
            if (n == 1) begin
                total++; if (SLEEP_ACK !== 1'b0) begin bad++; $display("FAIL wake_ack got=%b exp=0", SLEEP_ACK); end
            end
            if (RD_VALID) begin got = 1'b1; d = RD_DATA; end
        end
        RD_REQ = 1'b0;
        total++; if (!got || n != int'(WAKE) + 2) begin bad++; $display("FAIL wake_latency got=%0d exp=%0d", n, WAKE + 2); end
        total++; if (d !== 12'hB11) begin bad++; $display("FAIL wake_data got=%h exp=b11", d); end
        @(negedge CLK);
    endtask
`endif

    task automatic test_reset_mid_drain();
        for (int c = 0; c < 3; c++) begin
            RD_REQ = 1'b1; RD_ADDR = 15'h0020;
            WR_VALID = 1'b1; WR_ADDR = 15'(15'h0300 + c); WR_DATA = 12'(12'h700 + c);
            @(negedge CLK);
        end
        WR_VALID = 1'b0;
`ifdef SPB_SLEEP_EN
        SLEEP_REQ = 1'b1;
        @(negedge CLK);
`endif
        total++; if (FIFO_LEVEL !== 3'd3) begin bad++; $display("FAIL mid_level got=%0d exp=3", FIFO_LEVEL); end
        total++; if (RD_VALID !== 1'b1) begin bad++; $display("FAIL mid_valid got=%b exp=1", RD_VALID); end
        #2 RESET_N = 1'b0;
        #1;
        total++; if (WR_READY !== 1'b0) begin bad++; $display("FAIL arst_ready got=%b exp=0", WR_READY); end
        total++; if (RD_VALID !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", RD_VALID); end
        total++; if (RD_DATA !== 12'h000) begin bad++; $display("FAIL arst_data got=%h exp=000", RD_DATA); end
        total++; if (FIFO_LEVEL !== 3'd0) begin bad++; $display("FAIL arst_level got=%0d exp=0", FIFO_LEVEL); end
`ifdef SPB_SLEEP_EN
        total++; if (SLEEP_ACK !== 1'b0) begin bad++; $display("FAIL arst_ack got=%b exp=0", SLEEP_ACK); end
        SLEEP_REQ = 1'b0;
`endif
        RD_REQ = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        total++; if (WR_READY !== 1'b1) begin bad++; $display("FAIL rerun_ready got=%b exp=1", WR_READY); end
        total++; if (FIFO_LEVEL !== 3'd0) begin bad++; $display("FAIL rerun_level got=%0d exp=0", FIFO_LEVEL); end
    endtask

    initial begin
        RESET_N  = 1'b1;
        WR_VALID = 1'b0;
        WR_ADDR  = '0;
        WR_DATA  = '0;
        RD_REQ   = 1'b0;
        RD_ADDR  = '0;
`ifdef SPB_SLEEP_EN
        SLEEP_REQ = 1'b0;
`endif
        #2 RESET_N = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_no_stall();
        test_no_forward();
`ifdef SPB_SLEEP_EN
        test_sleep();
`endif
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spram_pixel_buffer.md
# spram_pixel_buffer

Parametrised pixel frame store built from 1–4 SP256K single-port SRAM banks. It sits between the OV7670 capture path (writer) and the VGA scan-out path (reader) in one clock domain. Writes pass through a small FIFO so that reads always win bank conflicts. An optional sleep handshake drains pending writes and powers the banks down.

## Interface
- NUM_BANKS, 2, number of SP256K banks (1, 2 or 4); AW = 14 + log2(NUM_BANKS)
- PIXEL_W, 12, stored pixel width (1..16); zero-padded to 16 on write, upper bits dropped on read
- WFIFO_DEPTH, 4, write FIFO entries (power of two, 2..16)
- WAKE_CYCLES, 8, cycles held after SLEEP deasserts before access resumes (≥1)
- CLK  in  1  single clock
- RESET_N  in  1  asynchronous, active-low reset
- WR_VALID  in  1  writer presents pixel
- WR_READY  out  1  FIFO accepts pixel; transfer when WR_VALID & WR_READY
- WR_ADDR  in  AW  pixel address; top log2(NUM_BANKS) bits select bank
- WR_DATA  in  PIXEL_W  pixel
- RD_REQ  in  1  read request, one per cycle allowed
- RD_ADDR  in  AW  read address
- RD_VALID  out  1  RD_DATA valid
- RD_DATA  out  PIXEL_W  read pixel
- FIFO_LEVEL  out  log2(WFIFO_DEPTH)+1  pending writes
- SLEEP_REQ  in  1  request power-down (only when SPB_SLEEP_EN is defined)
- SLEEP_ACK  out  1  banks asleep (only when SPB_SLEEP_EN is defined)

## Operation
- Reset values: WR_READY=0 during reset and 1 from the first cycle after release. RD_VALID=0, RD_DATA=0, FIFO_LEVEL=0, SLEEP_ACK=0. FIFO is emptied; FSM goes to RUN. SPRAM contents are neither cleared nor guaranteed.
- Reads have absolute priority. An RD_REQ in RUN drives CS on the addressed bank that cycle, with WE=0.
- Write drain: each cycle, the FIFO head is written (WE=1, MASKWE=4'b1111) if its bank is not being read that cycle. Otherwise it stalls. At most one write is issued per cycle.
- Different-bank read and write proceed in the same cycle.
- WR_READY = !full & (state==RUN). There is no full-FIFO bypass: a pop in the same cycle does not raise READY for that cycle.
- No forwarding. A read of an address whose write is still in the FIFO returns the old contents.
- RD_REQ outside RUN is ignored: no bank access and RD_VALID stays 0.
- All bank STDBY=0 and PWROFF_N=1. SLEEP is driven only by the FSM.
- Address wraps naturally; no bounds check is needed because AW covers all banks exactly.

## Timing
- Write: accepted at edge N. Earliest SPRAM write is in cycle N+1 (FIFO registered).
- Read: RD_REQ at cycle N gives RD_VALID=1 and RD_DATA in cycle N+1, selected by the registered bank index. Fully pipelined at 1 read per cycle.
- Worst-case write stall equals the length of a same-bank read burst; FIFO_LEVEL reports the backlog.
- Simultaneous push and pop leave FIFO_LEVEL unchanged.

## Configuration
- SPB_SLEEP_EN defined enables FSM states RUN → DRAIN → SLEEP → WAKE → RUN:
  - RUN → DRAIN when SLEEP_REQ=1. WR_READY drops and reads are still served.
  - DRAIN → SLEEP when the FIFO is empty. All banks get SLEEP=1 and CS=0; SLEEP_ACK=1.
  - SLEEP → WAKE when SLEEP_REQ=0. SLEEP_ACK drops and SLEEP goes to 0.
  - WAKE counts WAKE_CYCLES, then returns to RUN.
  - SLEEP_REQ dropping in DRAIN returns to RUN.
  - Reset in any state forces RUN.
- Undefined: the SLEEP_REQ/SLEEP_ACK ports are absent, the FSM is fixed at RUN, and SLEEP is tied 0.

## Structure
- spb_pkg: state enum (RUN, DRAIN, SLEEP, WAKE), bank-index function, SPRAM_AW=14, SPRAM_DW=16.
- Sub-module spb_wr_fifo: synchronous FIFO holding {addr, data}, with level output and async active-low reset.
- Top instantiates NUM_BANKS SP256K via a generate loop, plus a read-bank pipeline register.

## Test plan
- Write 0x0AB to 0x00010 and 0xFFF to 0x04010 (NUM_BANKS=2); later RD_REQ at each → RD_DATA 0x0AB, then 0xFFF, each 1 cycle after its request.
- Continuous bank-0 reads for 10 cycles while writing 6 pixels to bank 0 (WFIFO_DEPTH=4):
  - WR_READY falls after 4 accepted and FIFO_LEVEL=4.
  - Writes complete only after the reads stop.
  - All 6 pixels read back correctly.
- Bank-1 writes during continuous bank-0 reads → no stall; FIFO_LEVEL ≤ 1.
- Write 0x123 to address A and read A in the next cycle while the write is stalled → old value returned; a read after drain returns 0x123.
- SPB_SLEEP_EN with 3 queued writes then SLEEP_REQ=1:
  - SLEEP_ACK rises after the FIFO empties.
  - RD_REQ while asleep → RD_VALID=0.
  - After release, first access is served exactly WAKE_CYCLES+1 cycles later and data is retained.
- RESET_N pulsed low mid-drain with FIFO_LEVEL=3 → all outputs at reset values immediately, FSM RUN, FIFO_LEVEL=0.
